ps2_key_rx: RTL and testbench
=============================

# ps2_key_rx

PS/2 keyboard receiver that deserializes device-to-host frames from the keyboard's clock/data lines, decodes make/break and extended prefixes, and maintains a held-key bitmap for the five game controls. It sits beside the button debouncers in the top level and drives the same 5-bit movement vector `mario` consumes, so keyboard and board buttons are interchangeable control sources. Runs on the 100 MHz system clock.

## Interface
- `TIMEOUT_CYCLES`, 200000: system-clock cycles without a ps2c falling edge mid-frame before the frame is abandoned (2 ms at 100 MHz).
- `clk`  input  1  system clock, 100 MHz.
- `rst`  input  1  asynchronous, active-low reset.
- `ps2c`  input  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2d`  input  1  raw PS/2 data from the keyboard, asynchronous.
- `code`  output  8  last accepted scan-code byte, held until the next accepted byte.
- `code_valid`  output  1  one-cycle pulse when `code` updates.
- `is_ext`  output  1  E0 prefix preceded the byte in `code`; qualified by `code_valid`.
- `is_break`  output  1  F0 prefix preceded the byte in `code`; qualified by `code_valid`.
- `frame_err`  output  1  one-cycle pulse on bad start/stop/parity or timeout.
- `move_state`  output  5  held keys: [0] up (E0 75), [1] down (E0 72), [2] left (E0 6B), [3] right (E0 74), [4] jump (29, space).

## Operation
- Input conditioning: `ps2c` and `ps2d` each pass through a 2-FF synchronizer; a third `ps2c` register gives the falling-edge strobe (prev=1, cur=0). Data is sampled only on that strobe.
- Bit FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on strobe, data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, pulse `frame_err`.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on strobe, the frame is good if stop=1 and (data bits + parity) has odd weight; otherwise pulse `frame_err`. Return to IDLE either way.
- Timeout: a counter clears on every strobe and increments in every non-IDLE state. When it reaches `TIMEOUT_CYCLES-1`: go to IDLE, pulse `frame_err`, and clear the prefix flags. The counter is held at 0 in IDLE.
- Prefix decoder, run on each good frame:
  - Byte E0: set `ext_pend`. No `code_valid`.
  - Byte F0: set `brk_pend`. No `code_valid`.
  - Any other byte: load `code`, set `is_ext` = `ext_pend` and `is_break` = `brk_pend`, pulse `code_valid`, then clear both pending flags.
- Key map: on `code_valid`, if (`is_ext`, `code`) matches a mapped key, the corresponding `move_state` bit is set to !`is_break`. All other codes leave `move_state` unchanged. Autorepeat makes are idempotent.
- A frame error discards the partial byte and does not change `code`, `move_state` or the pending flags, except a timeout, which clears the pending flags.

## Timing
- Reset values: `code`=8'h00, `code_valid`=0, `is_ext`=0, `is_break`=0, `frame_err`=0, `move_state`=5'b0. FSM=IDLE, pending flags 0, timeout counter 0.
- Reset mid-frame aborts immediately. No partial output is produced.
- Latency: a ps2c falling edge at the pin is visible as a strobe 3 clk later. `code_valid` and the `move_state` update are registered on the cycle after the STOP strobe, i.e. STOP-edge-to-`code_valid` is 4 clk, and `move_state` changes on the same cycle `code_valid` is high.
- `code_valid` and `frame_err` are never high in the same cycle, and each is high for at most 1 cycle per frame.
- Timeout and strobe in the same cycle: the strobe wins and the counter clears.
- Counter width is ceil(log2(`TIMEOUT_CYCLES`)) bits, which is 18 for the default.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: an odd-parity failure rejects the frame and pulses `frame_err`.
  - Undefined: the parity bit is captured but ignored, and frame validity depends only on the start and stop bits.

## Test plan
- Reset with `ps2c`/`ps2d` idle high -> all outputs 0. Send frame 29 (space make) -> `code`=29, `code_valid` pulse, `is_ext`=0, `is_break`=0, `move_state`=5'b10000.
- Send E0 75 -> one `code_valid` pulse only, `code`=75, `is_ext`=1, `move_state`[0]=1. Then send E0 F0 75 -> `is_ext`=1, `is_break`=1, `move_state`[0]=0.
- Send E0 6B then E0 74 (left and right held) -> `move_state`=5'b01100. Then send F0 29 with space not held -> `move_state` unchanged at 5'b01100.
- Send frame 1C with parity bit flipped -> with `PS2_PARITY_CHECK_EN` defined: `frame_err` pulse, no `code_valid`, `code` unchanged. With it undefined: `code`=1C and `code_valid` pulses.
- Send start bit plus 4 data bits, then hold `ps2c` high for `TIMEOUT_CYCLES` clk -> `frame_err` pulse and FSM back in IDLE. A following full frame 29 decodes correctly.
- Send E0, assert `rst` low for 2 clk mid-frame, release, then send 72 -> `is_ext`=0 and `move_state`=0, because the prefix was cleared by reset.

Source files
------------

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard frame receiver with E0/F0 prefix decode and a held-key bitmap; `PS2_PARITY_CHECK_EN enables odd-parity rejection
module ps2_key_rx #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       frame_err,
  output logic [4:0] move_state
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic c1, c2, c3, d1, d2;
  logic strobe, good, frame_ok, tmo, par, ext_pend, brk_pend, mk;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [CW-1:0] cnt;
  logic [4:0] move_next;
  assign strobe = c3 & ~c2;
`ifdef PS2_PARITY_CHECK_EN
  assign good = d2 & (^{shreg, par});
`else
  assign good = d2;
`endif
  // two-stage synchronizers, plus a third ps2c stage for falling-edge detection
  always_ff @(posedge clk or negedge rst)
    if (!rst) {c1, c2, c3, d1, d2} <= 5'b11111;
    else {c1, c2, c3, d1, d2} <= {ps2c, c1, c2, ps2d, d1};
  // bit-level frame FSM with inactivity timeout; strobe beats timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      tmo <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      tmo <= 1'b0;
      cnt <= (state == IDLE || strobe || cnt == CMAX) ? '0 : cnt + 1'b1;
      if (strobe)
        case (state)
          IDLE: if (d2) frame_err <= 1'b1;
                else begin
                  state <= DATA;
                  bit_cnt <= '0;
                end
          DATA: begin
            shreg <= {d2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= d2;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            frame_ok <= good;
            frame_err <= ~good;
          end
        endcase
      else if (state != IDLE && cnt == CMAX) begin
        state <= IDLE;
        frame_err <= 1'b1;
        tmo <= 1'b1;
      end
    end
  // next held-key bitmap for the byte just received
  always_comb begin
    mk = ~brk_pend;
    move_next[0] = (ext_pend && shreg == 8'h75) ? mk : move_state[0];
    move_next[1] = (ext_pend && shreg == 8'h72) ? mk : move_state[1];
    move_next[2] = (ext_pend && shreg == 8'h6B) ? mk : move_state[2];
    move_next[3] = (ext_pend && shreg == 8'h74) ? mk : move_state[3];
    move_next[4] = (!ext_pend && shreg == 8'h29) ? mk : move_state[4];
  end
  // prefix decoder and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      code <= 8'h00;
      code_valid <= 1'b0;
      is_ext <= 1'b0;
      is_break <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      move_state <= 5'b0;
    end else begin
      code_valid <= 1'b0;
      if (tmo) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (frame_ok) begin
        if (shreg == 8'hE0) ext_pend <= 1'b1;
        else if (shreg == 8'hF0) brk_pend <= 1'b1;
        else begin
          code <= shreg;
          is_ext <= ext_pend;
          is_break <= brk_pend;
          code_valid <= 1'b1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          move_state <= move_next;
        end
      end
    end
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: table-driven check of PS/2 frame decode, prefixes, key map, parity, timeout and reset
module tb_ps2_key_rx;
  localparam int TO = 500;
  logic clk = 1'b0, rst = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
  logic [7:0] code;
  logic code_valid, is_ext, is_break, frame_err;
  logic [4:0] move_state;
  int pass_cnt = 0, total = 0;
  int nv = 0, ne = 0, both = 0, dbl = 0;
  logic [7:0] lc = 8'h00;
  logic le = 1'b0, lb = 1'b0, pcv = 1'b0;

  ps2_key_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .code(code),
    .code_valid(code_valid), .is_ext(is_ext), .is_break(is_break),
    .frame_err(frame_err), .move_state(move_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) begin
      nv++;
      lc = code;
      le = is_ext;
      lb = is_break;
    end
    if (frame_err) ne++;
    if (code_valid && frame_err) both++;
    if (code_valid && pcv) dbl++;
    pcv = code_valid;
  end

  typedef struct {
    logic [7:0] b [3];
    int n;
    bit flip;
    logic [7:0] e_code;
    bit e_ext, e_brk;
    logic [4:0] e_move;
    int e_nv, e_ne;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (5) @(posedge clk);
    ps2c = 1'b0;
    repeat (10) @(posedge clk);
    ps2c = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip);
    send_bit(1'b1);
    repeat (10) @(posedge clk);
  endtask

  task automatic partial_then_timeout();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2d = 1'b1;
    repeat (TO + 50) @(posedge clk);
  endtask

  vec_t v [12];

  initial begin
    int nv0, ne0;
    v[0]  = '{'{8'h29, 8'h00, 8'h00}, 1, 0, 8'h29, 0, 0, 5'b10000, 1, 0};
    v[1]  = '{'{8'hE0, 8'h75, 8'h00}, 2, 0, 8'h75, 1, 0, 5'b10001, 1, 0};
    v[2]  = '{'{8'hE0, 8'hF0, 8'h75}, 3, 0, 8'h75, 1, 1, 5'b10000, 1, 0};
    v[3]  = '{'{8'hF0, 8'h29, 8'h00}, 2, 0, 8'h29, 0, 1, 5'b00000, 1, 0};
    v[4]  = '{'{8'hE0, 8'h6B, 8'h00}, 2, 0, 8'h6B, 1, 0, 5'b00100, 1, 0};
    v[5]  = '{'{8'hE0, 8'h74, 8'h00}, 2, 0, 8'h74, 1, 0, 5'b01100, 1, 0};
    v[6]  = '{'{8'hF0, 8'h29, 8'h00}, 2, 0, 8'h29, 0, 1, 5'b01100, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    v[7]  = '{'{8'h1C, 8'h00, 8'h00}, 1, 1, 8'h29, 0, 1, 5'b01100, 0, 1};
`else
    v[7]  = '{'{8'h1C, 8'h00, 8'h00}, 1, 1, 8'h1C, 0, 0, 5'b01100, 1, 0};
`endif
    v[8]  = '{'{8'hE0, 8'h72, 8'h00}, 2, 0, 8'h72, 1, 0, 5'b01110, 1, 0};
    v[9]  = '{'{8'hE0, 8'hF0, 8'h72}, 3, 0, 8'h72, 1, 1, 5'b01100, 1, 0};
    v[10] = '{'{8'h75, 8'h00, 8'h00}, 1, 0, 8'h75, 0, 0, 5'b01100, 1, 0};
    v[11] = '{'{8'hE0, 8'h29, 8'h00}, 2, 0, 8'h29, 1, 0, 5'b01100, 1, 0};
    repeat (4) @(posedge clk);
    #1;
    chk("rst_code", code, 0);
    chk("rst_valid", code_valid, 0);
    chk("rst_ext", is_ext, 0);
    chk("rst_brk", is_break, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_move", move_state, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      nv0 = nv;
      ne0 = ne;
      for (int j = 0; j < v[i].n; j++) send_frame(v[i].b[j], v[i].flip);
      #1;
      chk($sformatf("v%0d_code", i), code, v[i].e_code);
      chk($sformatf("v%0d_ext", i), le, v[i].e_ext);
      chk($sformatf("v%0d_brk", i), lb, v[i].e_brk);
      chk($sformatf("v%0d_move", i), move_state, v[i].e_move);
      chk($sformatf("v%0d_nvalid", i), nv - nv0, v[i].e_nv);
      chk($sformatf("v%0d_nerr", i), ne - ne0, v[i].e_ne);
    end
    nv0 = nv;
    ne0 = ne;
    send_bit(1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("badstart_err", ne - ne0, 1);
    chk("badstart_valid", nv - nv0, 0);
    nv0 = nv;
    ne0 = ne;
    partial_then_timeout();
    #1;
    chk("tmo_err", ne - ne0, 1);
    chk("tmo_valid", nv - nv0, 0);
    chk("tmo_idle", dut.state, 0);
    nv0 = nv;
    send_frame(8'hE0, 0);
    partial_then_timeout();
    send_frame(8'h72, 0);
    #1;
    chk("tmo_clr_ext", le, 0);
    chk("tmo_clr_move", move_state, 5'b01100);
    send_frame(8'h29, 0);
    #1;
    chk("post_tmo_code", code, 8'h29);
    chk("post_tmo_move", move_state, 5'b11100);
    chk("post_tmo_valid", nv - nv0, 2);
    send_frame(8'hE0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    @(posedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    #1;
    chk("midrst_move", move_state, 0);
    chk("midrst_code", code, 0);
    repeat (10) @(posedge clk);
    nv0 = nv;
    send_frame(8'h72, 0);
    #1;
    chk("rst_pfx_code", lc, 8'h72);
    chk("rst_pfx_ext", le, 0);
    chk("rst_pfx_move", move_state, 0);
    chk("rst_pfx_valid", nv - nv0, 1);
    chk("valid_err_overlap", both, 0);
    chk("valid_width", dbl, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
